// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding and
// the round-robin pick used when both requesters compete for the memory port.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_IFU = 1'b0,
    ARB_OWNER_LSU = 1'b1
  } arb_owner_e;

  // Winner is only meaningful when at least one requester is valid.
  function automatic arb_owner_e rr_pick(input logic ifu_valid, input logic lsu_valid,
                                         input arb_owner_e last_owner);
    if (ifu_valid && lsu_valid) begin
      return (last_owner == ARB_OWNER_LSU) ? ARB_OWNER_IFU : ARB_OWNER_LSU;
    end
    return ifu_valid ? ARB_OWNER_IFU : ARB_OWNER_LSU;
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Response timeout counter: cleared on accept, counts while a transaction is
// outstanding and flags expiry. TIMEOUT_CYC=0 disables it.
module mem_arbiter_timer #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] LIMIT = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [TW-1:0] SAT   = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC) : '0;

  logic [TW-1:0] count;

  // The accept cycle counts as the first elapsed cycle, hence the load of 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= TW'(1);
    end else if (enable && (count != SAT)) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && enable && (count >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one
// transaction at a time, with round-robin ties and a hung-slave timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  output logic                ifu_reqReady,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  output logic                lsu_reqReady,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                resp_err,
  output logic                mem_reqValid,
  input  logic                mem_reqReady,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);

  arb_state_e state;
  arb_owner_e owner;
  arb_owner_e last_owner;
  arb_owner_e pick;
  logic       in_idle;
  logic       accept;
  logic       complete;
  logic       expired;
  logic       timeout;
  logic       resp_fire;
  logic [DATA_W-1:0] resp_data;

  // Outputs are gated with reset so a transaction in flight is dropped silently.
  assign pick         = rr_pick(ifu_reqValid, lsu_reqValid, last_owner);
  assign in_idle      = (state == ARB_IDLE) && !reset;
  assign ifu_reqReady = in_idle && ifu_reqValid && (pick == ARB_OWNER_IFU);
  assign lsu_reqReady = in_idle && lsu_reqValid && (pick == ARB_OWNER_LSU);
  assign accept       = ifu_reqReady || lsu_reqReady;

  assign complete  = (state == ARB_WAIT) && mem_respValid && !reset;
  assign timeout   = expired && !complete && !reset;
  assign resp_fire = complete || timeout;
  assign resp_data = complete ? mem_rdata : '0;

  assign ifu_respValid = resp_fire && (owner == ARB_OWNER_IFU);
  assign lsu_respValid = resp_fire && (owner == ARB_OWNER_LSU);
  assign ifu_rdata     = ifu_respValid ? resp_data : '0;
  assign lsu_rdata     = lsu_respValid ? resp_data : '0;
  assign resp_err      = complete ? mem_err : timeout;
  assign mem_reqValid  = (state == ARB_REQ) && !reset && !expired;

  mem_arbiter_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (state != ARB_IDLE),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= ARB_OWNER_LSU;
      last_owner <= ARB_OWNER_LSU;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (accept) begin
            owner      <= pick;
            last_owner <= pick;
            state      <= ARB_REQ;
            if (pick == ARB_OWNER_IFU) begin
              mem_addr  <= ifu_addr;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end else begin
              mem_addr  <= lsu_addr;
              mem_wdata <= lsu_wdata;
              mem_wmask <= lsu_wmask;
            end
          end
        end
        ARB_REQ: begin
          if (timeout) begin
            state <= ARB_IDLE;
          end else if (mem_reqReady) begin
            state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (resp_fire) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant table, transaction table and hand
// sequences for ties, stalled stores, timeout and reset mid-transaction.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          ifu_reqValid, ifu_reqReady, ifu_respValid;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_reqValid, lsu_reqReady, lsu_respValid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          resp_err;
  logic          mem_reqValid, mem_reqReady, mem_respValid, mem_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_reqReady(ifu_reqReady), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_reqReady(lsu_reqReady), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .resp_err(resp_err),
    .mem_reqValid(mem_reqValid), .mem_reqReady(mem_reqReady), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  typedef struct {
    string       name;
    logic        useLsu;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  expMask;
  } txn_t;

  typedef struct {
    logic ifuV;
    logic lsuV;
    logic expIfu;
    logic expLsu;
  } grant_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic quietInputs();
    ifu_reqValid = 0; ifu_addr = '0;
    lsu_reqValid = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_reqReady = 0; mem_respValid = 0; mem_rdata = '0; mem_err = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ifu_respValid"}, ifu_respValid, 0);
    checkOutput({tag, " lsu_respValid"}, lsu_respValid, 0);
    checkOutput({tag, " resp_err"}, resp_err, 0);
    checkOutput({tag, " ifu_rdata"}, ifu_rdata, 0);
    checkOutput({tag, " lsu_rdata"}, lsu_rdata, 0);
    checkOutput({tag, " mem_reqValid"}, mem_reqValid, 0);
    checkOutput({tag, " mem_addr"}, mem_addr, 0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, " mem_wmask"}, {28'd0, mem_wmask}, 0);
  endtask

  // Called mid accept+1 cycle: ready that cycle, respond two cycles later.
  task automatic serveResp(input logic [31:0] rd, input logic er);
    mem_reqReady = 1;
    @(negedge clock);
    mem_reqReady = 0;
    @(negedge clock);
    mem_respValid = 1; mem_rdata = rd; mem_err = er;
    #1;
  endtask

  task automatic endResp();
    mem_respValid = 0; mem_rdata = '0; mem_err = 0;
  endtask

  task automatic applyStimulus(input txn_t t);
    @(negedge clock);
    if (t.useLsu) begin
      lsu_reqValid = 1; lsu_addr = t.addr; lsu_wdata = t.wdata; lsu_wmask = t.wmask;
    end else begin
      ifu_reqValid = 1; ifu_addr = t.addr;
    end
    #1;
    checkOutput({t.name, " reqReady"}, t.useLsu ? lsu_reqReady : ifu_reqReady, 1);
    @(negedge clock);
    ifu_reqValid = 0; lsu_reqValid = 0;
    #1;
    checkOutput({t.name, " mem_reqValid"}, mem_reqValid, 1);
    checkOutput({t.name, " mem_addr"}, mem_addr, t.addr);
    checkOutput({t.name, " mem_wmask"}, {28'd0, mem_wmask}, {28'd0, t.expMask});
    if (t.useLsu) checkOutput({t.name, " mem_wdata"}, mem_wdata, t.wdata);
    mem_reqReady = 1;
    @(negedge clock);
    mem_reqReady = 0;
    #1;
    checkOutput({t.name, " wait reqValid"}, mem_reqValid, 0);
    checkOutput({t.name, " early resp"}, ifu_respValid | lsu_respValid, 0);
    @(negedge clock);
    mem_respValid = 1; mem_rdata = t.rdata; mem_err = t.err;
    #1;
    checkOutput({t.name, " respValid"}, t.useLsu ? lsu_respValid : ifu_respValid, 1);
    checkOutput({t.name, " rdata"}, t.useLsu ? lsu_rdata : ifu_rdata, t.rdata);
    checkOutput({t.name, " resp_err"}, resp_err, t.err);
    checkOutput({t.name, " other respValid"}, t.useLsu ? ifu_respValid : lsu_respValid, 0);
    checkOutput({t.name, " other rdata"}, t.useLsu ? ifu_rdata : lsu_rdata, 0);
    @(negedge clock);
    endResp();
    #1;
    checkOutput({t.name, " pulse end"}, ifu_respValid | lsu_respValid, 0);
    checkOutput({t.name, " err end"}, resp_err, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t   txns[5];
    grant_t gv[4];

    gv[0] = '{0, 0, 0, 0};
    gv[1] = '{1, 0, 1, 0};
    gv[2] = '{0, 1, 0, 1};
    gv[3] = '{1, 1, 1, 0};

    txns[0] = '{"ifu_fetch", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0013, 1'b0, 4'h0};
    txns[1] = '{"lsu_load",  1'b1, 32'h0000_2000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 4'h0};
    txns[2] = '{"lsu_err",   1'b1, 32'h0000_3004, 32'h0, 4'h0, 32'h0000_0055, 1'b1, 4'h0};
    txns[3] = '{"lsu_store", 1'b1, 32'h0000_4008, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 4'hF};
    txns[4] = '{"ifu_err",   1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hABCD_0001, 1'b1, 4'h0};

    quietInputs();
    reset = 1;
    repeat (3) @(negedge clock);
    reset = 0;
    #1;
    checkAllZero("reset");
    checkOutput("reset ifu_reqReady", ifu_reqReady, 0);
    checkOutput("reset lsu_reqReady", lsu_reqReady, 0);
    mem_respValid = 1; mem_rdata = 32'h77; mem_err = 1;
    #1;
    checkAllZero("idle stray");
    @(negedge clock);
    endResp();

    // Grant table after reset: last_owner is LSU, so a tie goes to IFU.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      ifu_reqValid = gv[i].ifuV; lsu_reqValid = gv[i].lsuV;
      #1;
      checkOutput($sformatf("grant%0d ifu_reqReady", i), ifu_reqReady, gv[i].expIfu);
      checkOutput($sformatf("grant%0d lsu_reqReady", i), lsu_reqReady, gv[i].expLsu);
      #1;
      ifu_reqValid = 0; lsu_reqValid = 0;
    end

    // Round-robin ties: IFU, then LSU, then IFU again.
    @(negedge clock);
    ifu_reqValid = 1; ifu_addr = 32'h100; lsu_reqValid = 1; lsu_addr = 32'h200;
    #1;
    checkOutput("tie1 ifu_reqReady", ifu_reqReady, 1);
    checkOutput("tie1 lsu_reqReady", lsu_reqReady, 0);
    @(negedge clock);
    ifu_reqValid = 0;
    #1;
    checkOutput("tie1 busy lsu_reqReady", lsu_reqReady, 0);
    checkOutput("tie1 mem_addr", mem_addr, 32'h100);
    serveResp(32'h11, 0);
    checkOutput("tie1 ifu_respValid", ifu_respValid, 1);
    @(negedge clock);
    endResp();
    ifu_reqValid = 1;
    #1;
    checkOutput("tie2 lsu_reqReady", lsu_reqReady, 1);
    checkOutput("tie2 ifu_reqReady", ifu_reqReady, 0);
    @(negedge clock);
    lsu_reqValid = 0;
    #1;
    checkOutput("tie2 mem_addr", mem_addr, 32'h200);
    serveResp(32'h22, 0);
    checkOutput("tie2 lsu_respValid", lsu_respValid, 1);
    checkOutput("tie2 lsu_rdata", lsu_rdata, 32'h22);
    @(negedge clock);
    endResp();
    lsu_reqValid = 1;
    #1;
    checkOutput("tie3 ifu_reqReady", ifu_reqReady, 1);
    checkOutput("tie3 lsu_reqReady", lsu_reqReady, 0);
    @(negedge clock);
    ifu_reqValid = 0; lsu_reqValid = 0;
    serveResp(32'h33, 0);
    checkOutput("tie3 ifu_respValid", ifu_respValid, 1);
    @(negedge clock);
    endResp();

    for (int i = 0; i < 5; i++) applyStimulus(txns[i]);

    // Store stalled five cycles; the response lands on the expiry cycle and must win.
    @(negedge clock);
    lsu_reqValid = 1; lsu_addr = 32'h1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      lsu_reqValid = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_addr = '0;
      #1;
      checkOutput($sformatf("stall%0d mem_reqValid", k), mem_reqValid, 1);
      checkOutput($sformatf("stall%0d mem_addr", k), mem_addr, 32'h1000);
      checkOutput($sformatf("stall%0d mem_wdata", k), mem_wdata, 32'hDEAD_BEEF);
      checkOutput($sformatf("stall%0d mem_wmask", k), {28'd0, mem_wmask}, 32'h3);
      checkOutput($sformatf("stall%0d lsu_respValid", k), lsu_respValid, 0);
      if (k == 6) mem_reqReady = 1;
    end
    @(negedge clock);
    mem_reqReady = 0; mem_respValid = 1; mem_rdata = 32'h0; mem_err = 0;
    #1;
    checkOutput("stall lsu_respValid", lsu_respValid, 1);
    checkOutput("stall resp_err", resp_err, 0);
    @(negedge clock);
    endResp();

    // Hung slave: forced error response exactly seven cycles after accept.
    @(negedge clock);
    ifu_reqValid = 1; ifu_addr = 32'h40;
    @(negedge clock);
    ifu_reqValid = 0; mem_reqReady = 1;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clock);
      if (k == 2) mem_reqReady = 0;
      #1;
      checkOutput($sformatf("timeout c%0d ifu_respValid", k), ifu_respValid, (k == 7) ? 1 : 0);
      checkOutput($sformatf("timeout c%0d resp_err", k), resp_err, (k == 7) ? 1 : 0);
    end
    checkOutput("timeout ifu_rdata", ifu_rdata, 0);
    checkOutput("timeout lsu_respValid", lsu_respValid, 0);
    @(negedge clock);
    #1;
    checkOutput("post-timeout ifu_respValid", ifu_respValid, 0);
    lsu_reqValid = 1;
    #1;
    checkOutput("post-timeout idle lsu_reqReady", lsu_reqReady, 1);
    lsu_reqValid = 0;

    // Reset while waiting for a response, then a stray response after reset.
    @(negedge clock);
    lsu_reqValid = 1; lsu_addr = 32'h5000; lsu_wdata = 32'h99; lsu_wmask = 4'hF;
    @(negedge clock);
    lsu_reqValid = 0; mem_reqReady = 1;
    @(negedge clock);
    mem_reqReady = 0; reset = 1;
    @(negedge clock);
    reset = 0; mem_respValid = 1; mem_rdata = 32'hAA; mem_err = 1;
    #1;
    checkAllZero("rst-wait");
    @(negedge clock);
    endResp();
    ifu_reqValid = 1; lsu_reqValid = 1;
    #1;
    checkOutput("rst-wait tie ifu_reqReady", ifu_reqReady, 1);
    checkOutput("rst-wait tie lsu_reqReady", lsu_reqReady, 0);
    ifu_reqValid = 0; lsu_reqValid = 0;

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
